// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its picker.
package fifo_wr_arbiter_pkg;

  // Arbiter state encoding.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Width of an index into an n-entry vector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold values 0..max_val without wrapping.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational circular priority encoder. Returns the first set
// request bit found searching upward from last_id+1, wrapping NUM_REQ-1 -> 0.
// Shared between the write-side and read-side arbiters.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_id,
  output logic [IDX_W-1:0]   sel,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Walk offsets 1..NUM_REQ so last_id itself is checked last.
  always_comb begin
    sel  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((32'(last_id) + off) % NUM_REQ);
      if (!any && req[cand]) begin
        sel = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port between NUM_REQ
// requesters. A grant lasts one packet burst: it ends on an accepted beat
// carrying req_last or after MAX_BURST accepted beats, whichever comes first.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                          wr_clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wr_full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          busy
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam int unsigned CNT_W = cnt_width(MAX_BURST);

  // Requester 0 wins the first arbitration after reset.
  localparam logic [IDX_W-1:0] LAST_ID_RST = IDX_W'(NUM_REQ - 1);
  // beat_cnt value at which the next accepted beat closes the burst.
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(MAX_BURST - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0]       last_id_q, last_id_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic                   busy_q, busy_d;

  logic [IDX_W-1:0]       pick_sel;
  logic                   pick_any;
  logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];

  // Circular search for the next requester after the previous winner.
  fifo_wr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (req_valid),
    .last_id (last_id_q),
    .sel     (pick_sel),
    .any     (pick_any)
  );

  // Unpack the flat requester data bus into per-requester words.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // While granted, last_id_q is the granted index, so it steers the data mux.
  assign wr_data = data_arr[last_id_q];

  // Next-state, grant and handshake logic; writes are suppressed in a reset cycle.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_id_d  = last_id_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    wr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_BURST;
          gnt_d      = NUM_REQ'(1) << pick_sel;
          last_id_d  = pick_sel;
          beat_cnt_d = '0;
        end
      end

      ST_BURST: begin
        req_ready[last_id_q] = rst_n & ~wr_full;
        wr_en                = rst_n & ~wr_full & req_valid[last_id_q];
        if (wr_en) begin
          if (req_last[last_id_q] || (beat_cnt_q == CNT_LAST)) begin
            state_d    = ST_IDLE;
            gnt_d      = '0;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_BURST);
  end

  // State, grant and counter registers with synchronous reset.
  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      last_id_q  <= LAST_ID_RST;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_id_q  <= last_id_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;

  // Structural invariants of the grant and handshake outputs.
  a_gnt_onehot0: assert property (@(posedge wr_clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_rdy_onehot0: assert property (@(posedge wr_clk) disable iff (!rst_n) $onehot0(req_ready));
  a_no_wr_full:  assert property (@(posedge wr_clk) disable iff (!rst_n) !(wr_en && wr_full));

endmodule
